// File: rtl/inverse_key_scheduler.sv
// Iterative AES-128 inverse key schedule.
// Loads the last round key and walks backwards one round key per handshake,
// so no full key table is needed. Optional build macro INV_KEYGEN_FWD_EN makes
// i_key the cipher key and expands it forward internally before emitting.
module inverse_key_scheduler #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_key,
    input  logic         i_ready,
    output logic         o_busy,
    output logic         o_valid,
    output logic [127:0] o_roundKey,
    output logic [3:0]   o_roundNumber,
    output logic         o_last
);

`ifdef INV_KEYGEN_FWD_EN
    typedef enum logic [1:0] {IDLE, EMIT, EXPAND} state_t;
`else
    typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t       state;
    state_t       state_next;
    logic [127:0] key_reg;
    logic [127:0] key_next;
    logic [3:0]   round;
    logic [3:0]   round_next;
    logic [127:0] prev_key;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, zero maps to zero) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for rounds 1..10; anything else yields zero
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // G(x) = SubWord(RotWord(x)) ^ {rc,00,00,00}
    function automatic logic [31:0] g_func(input logic [31:0] x, input logic [7:0] rc);
        logic [31:0] rot;
        rot = {x[23:0], x[31:24]};
        return {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

    // Previous round key derived combinationally from the key register
    always_comb begin
        logic [31:0] w1, w2, w3;
        w3 = key_reg[31:0]  ^ key_reg[63:32];
        w2 = key_reg[63:32] ^ key_reg[95:64];
        w1 = key_reg[95:64] ^ key_reg[127:96];
        prev_key = {key_reg[127:96] ^ g_func(w3, rcon(round)), w1, w2, w3};
    end

`ifdef INV_KEYGEN_FWD_EN
    logic [127:0] fwd_key;

    // Next round key for the internal forward expansion
    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        n0 = key_reg[127:96] ^ g_func(key_reg[31:0], rcon(round + 4'd1));
        n1 = key_reg[95:64] ^ n0;
        n2 = key_reg[63:32] ^ n1;
        n3 = key_reg[31:0]  ^ n2;
        fwd_key = {n0, n1, n2, n3};
    end
`endif

    // State, key and round registers; reset clears everything so no key survives
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            key_reg <= '0;
            round   <= '0;
        end else begin
            state   <= state_next;
            key_reg <= key_next;
            round   <= round_next;
        end
    end

    // Next-state logic: load on start, step back one key per accepted handshake
    always_comb begin
        state_next = state;
        key_next   = key_reg;
        round_next = round;
        case (state)
            IDLE: begin
                if (i_start) begin
                    key_next = i_key;
`ifdef INV_KEYGEN_FWD_EN
                    round_next = 4'd0;
                    state_next = EXPAND;
`else
                    round_next = LAST_ROUND;
                    state_next = EMIT;
`endif
                end
            end
`ifdef INV_KEYGEN_FWD_EN
            EXPAND: begin
                key_next   = fwd_key;
                round_next = round + 4'd1;
                if (round + 4'd1 == LAST_ROUND) state_next = EMIT;
            end
`endif
            EMIT: begin
                if (i_ready) begin
                    if (round != 4'd0) begin
                        key_next   = prev_key;
                        round_next = round - 4'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_busy        = (state != IDLE);
    assign o_valid       = (state == EMIT);
    assign o_roundKey    = key_reg;
    assign o_roundNumber = round;
    assign o_last        = (state == EMIT) && (round == 4'd0);

endmodule
